// File: rtl/fmc_pkg.sv
// Shared types and helpers for the formal output checker: FSM encoding,
// default parameters and a saturating adder.
package fmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } fmc_state_e;

  localparam int FMC_WIDTH       = 8;
  localparam int FMC_SKIP_CYCLES = 1;
  localparam int FMC_RUN_CYCLES  = 10;
  localparam int FMC_ERR_W       = 16;
  localparam int FMC_CYC_W       = 16;

  // a + b clamped to 2^w-1; callers truncate the result back to w bits
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum = {1'b0, a} + {1'b0, b};
    sat_add = (sum > {1'b0, max}) ? max : sum[63:0];
  endfunction

endpackage

// File: rtl/fmc_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module fmc_popcount
  import fmc_pkg::*;
#(
  parameter int WIDTH = FMC_WIDTH
) (
  input  logic [WIDTH-1:0]           vec,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + $bits(cnt)'(vec[i]);
  end

endmodule

// File: rtl/formal_output_checker.sv
// On-chip scoreboard: compares fabric outputs with the benchmark each cycle,
// counts rising mismatch flags and records the first-failure signature.
module formal_output_checker
  import fmc_pkg::*;
#(
  parameter int WIDTH       = FMC_WIDTH,
  parameter int SKIP_CYCLES = FMC_SKIP_CYCLES,
  parameter int RUN_CYCLES  = FMC_RUN_CYCLES,
  parameter int ERR_W       = FMC_ERR_W,
  parameter int CYC_W       = FMC_CYC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [WIDTH-1:0] gfpga_i,
  input  logic [WIDTH-1:0] bench_i,
  input  logic [WIDTH-1:0] bench_dc_i,
  output logic [WIDTH-1:0] mismatch_o,
  output logic             err_rise_o,
  output logic [ERR_W-1:0] nb_error_o,
  output logic [CYC_W-1:0] cycle_o,
  output logic [CYC_W-1:0] first_cycle_o,
  output logic [WIDTH-1:0] first_mask_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o
);

  localparam int PC_W = $clog2(WIDTH+1);
  localparam int SK_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;

  fmc_state_e       state, state_nx;
  logic [SK_W-1:0]  skip_cnt;
  logic             first_seen;
  logic [WIDTH-1:0] cmp_new, rise;
  logic [PC_W-1:0]  rise_cnt;
  logic             run_start, in_check, last_run, leave_check;

  assign run_start   = start_i && (state == ST_IDLE || state == ST_DONE);
  assign in_check    = (state == ST_CHECK);
  assign last_run    = (cycle_o == CYC_W'(RUN_CYCLES-1));
  assign leave_check = in_check && (state_nx != ST_CHECK);

  assign cmp_new = (gfpga_i ^ bench_i) & ~bench_dc_i;
  assign rise    = cmp_new & ~mismatch_o;

  fmc_popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec (rise),
    .cnt (rise_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) state_nx = (SKIP_CYCLES == 0) ? ST_CHECK : ST_SKIP;
      ST_SKIP: begin
        if (stop_i)               state_nx = ST_DONE;
        else if (skip_cnt == '0)  state_nx = ST_CHECK;
      end
      ST_CHECK: if (stop_i || last_run) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == ST_SKIP) || (state == ST_CHECK);
    done_o = (state == ST_DONE);
    pass_o = (state == ST_DONE) && (nb_error_o == '0);
  end

  // The edge that leaves CHECK still accounts its comparison, but the
  // per-bit flags and rise pulse are dropped so DONE shows only totals.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_cnt      <= '0;
      mismatch_o    <= '0;
      err_rise_o    <= 1'b0;
      nb_error_o    <= '0;
      cycle_o       <= '0;
      first_cycle_o <= '0;
      first_mask_o  <= '0;
      first_seen    <= 1'b0;
    end else if (run_start) begin
      skip_cnt      <= SK_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES-1 : 0);
      mismatch_o    <= '0;
      err_rise_o    <= 1'b0;
      nb_error_o    <= '0;
      cycle_o       <= '0;
      first_cycle_o <= '0;
      first_mask_o  <= '0;
      first_seen    <= 1'b0;
    end else if (state == ST_SKIP) begin
      if (skip_cnt != '0) skip_cnt <= skip_cnt - SK_W'(1);
    end else if (in_check) begin
      mismatch_o <= leave_check ? '0 : cmp_new;
      err_rise_o <= !leave_check && (|rise);
      nb_error_o <= ERR_W'(sat_add(64'(nb_error_o), 64'(rise_cnt), ERR_W));
      cycle_o    <= CYC_W'(sat_add(64'(cycle_o), 64'd1, CYC_W));
      if ((|rise) && !first_seen) begin
        first_seen    <= 1'b1;
        first_cycle_o <= cycle_o;
        first_mask_o  <= rise;
      end
    end
  end

endmodule

// File: tb/tb_formal_output_checker.sv
// Scoreboard bench: the driver advances a behavioural model and queues the
// expected outputs; the monitor compares them after each clock edge.
module tb_formal_output_checker;

  localparam int W = 8, SKIP = 1, RUN = 10, EW = 16, CW = 16;

  logic clk = 1'b0, reset = 1'b1, start_i = 1'b0, stop_i = 1'b0;
  logic [W-1:0] gfpga_i = '0, bench_i = '0, bench_dc_i = '0;
  logic [W-1:0] mismatch_o, first_mask_o;
  logic err_rise_o, busy_o, done_o, pass_o;
  logic [EW-1:0] nb_error_o;
  logic [CW-1:0] cycle_o, first_cycle_o;

  formal_output_checker #(.WIDTH(W), .SKIP_CYCLES(SKIP), .RUN_CYCLES(RUN),
                          .ERR_W(EW), .CYC_W(CW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .gfpga_i(gfpga_i), .bench_i(bench_i), .bench_dc_i(bench_dc_i),
    .mismatch_o(mismatch_o), .err_rise_o(err_rise_o), .nb_error_o(nb_error_o),
    .cycle_o(cycle_o), .first_cycle_o(first_cycle_o), .first_mask_o(first_mask_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  mm;
    logic          er;
    logic [EW-1:0] nerr;
    logic [CW-1:0] cyc;
    logic [CW-1:0] fcyc;
    logic [W-1:0]  fmask;
    logic          busy, done, pass;
  } obs_t;

  obs_t act;
  assign act = {mismatch_o, err_rise_o, nb_error_o, cycle_o, first_cycle_o,
                first_mask_o, busy_o, done_o, pass_o};

  obs_t exp_q[$];
  int errors = 0, checks = 0;

  // Model: a run is "active" while skipping or checking; skip_left counts
  // the ignored cycles still to come, then every edge is a checked cycle.
  bit m_active, m_done, m_first, m_er;
  int m_skip_left, m_nerr, m_cyc, m_fcyc;
  logic [W-1:0] m_mm, m_fmask;

  task automatic model_clear();
    m_first = 0; m_er = 0; m_nerr = 0; m_cyc = 0; m_fcyc = 0;
    m_mm = '0; m_fmask = '0;
  endtask

  task automatic model_step(input bit rn, input bit st, input bit sp,
                            input logic [W-1:0] g, input logic [W-1:0] b,
                            input logic [W-1:0] dc);
    logic [W-1:0] nw, rs;
    bit fin;
    if (!rn) begin
      model_clear(); m_active = 0; m_done = 0; m_skip_left = 0;
    end else if (!m_active) begin
      if (st) begin model_clear(); m_active = 1; m_done = 0; m_skip_left = SKIP; end
    end else if (m_skip_left > 0) begin
      if (sp) begin m_active = 0; m_done = 1; end
      else m_skip_left--;
    end else begin
      nw = (g ^ b) & ~dc;
      rs = nw & ~m_mm;
      if (rs != 0 && !m_first) begin m_first = 1; m_fcyc = m_cyc; m_fmask = rs; end
      m_nerr = m_nerr + $countones(rs);
      if (m_nerr > 2**EW-1) m_nerr = 2**EW-1;
      fin = sp || (m_cyc == RUN-1);
      m_cyc = (m_cyc + 1 > 2**CW-1) ? 2**CW-1 : m_cyc + 1;
      m_mm = fin ? '0 : nw;
      m_er = !fin && (rs != 0);
      if (fin) begin m_active = 0; m_done = 1; end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.mm = m_mm; o.er = m_er; o.nerr = EW'(m_nerr); o.cyc = CW'(m_cyc);
    o.fcyc = CW'(m_fcyc); o.fmask = m_fmask;
    o.busy = m_active; o.done = m_done; o.pass = m_done && (m_nerr == 0);
    return o;
  endfunction

  task automatic apply(input bit st, input bit sp, input logic [W-1:0] g,
                       input logic [W-1:0] b, input logic [W-1:0] dc);
    start_i = st; stop_i = sp; gfpga_i = g; bench_i = b; bench_dc_i = dc;
    model_step(reset, st, sp, g, b, dc);
    exp_q.push_back(model_obs());
  endtask

  task automatic step(input bit st, input bit sp, input logic [W-1:0] g,
                      input logic [W-1:0] b, input logic [W-1:0] dc);
    @(negedge clk);
    apply(st, sp, g, b, dc);
  endtask

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, a, e);
    end
  endtask

  // Settle to the negedge after a run, so directed checks see final outputs.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic hold();
    apply(1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [W-1:0] err_mask(input int scn, input int k);
    logic [W-1:0] m;
    m = '0;
    case (scn)
      1: if (k >= 4) m = 8'h08;
      2: begin
        if (k >= 2) m = 8'h82;
        if (k == 2 || k >= 5) m[0] = 1'b1;
      end
      3: m = '1;
      6: if ($urandom_range(0, 3) == 0) m = W'(1) << $urandom_range(0, W-1);
      7: if (k >= 1) m = 8'h24;
      default: m = '0;
    endcase
    return m;
  endfunction

  // One run: start edge, SKIP edges, then checked cycles until RUN or stop_k.
  task automatic run(input int scn, input int stop_k, input logic [W-1:0] dc, input bit rnd_start);
    logic [W-1:0] b, d;
    bit st;
    step(1'b1, 1'b0, W'($urandom), W'($urandom), dc);
    for (int j = 0; j < SKIP; j++) step(1'b0, 1'b0, W'($urandom), W'($urandom), dc);
    for (int k = 0; k < RUN; k++) begin
      b  = (scn == 0) ? W'(k) : W'($urandom);
      d  = (scn == 6) ? (W'($urandom) & W'($urandom)) : dc;
      st = (scn == 5 && k == 1) || (rnd_start && $urandom_range(0, 4) == 0);
      step(st, k == stop_k, b ^ err_mask(scn, k), b, d);
      if (k == stop_k) break;
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got mm=%h er=%b nerr=%0d cyc=%0d fcyc=%0d fmask=%h bdp=%b%b%b, expected mm=%h er=%b nerr=%0d cyc=%0d fcyc=%0d fmask=%h bdp=%b%b%b",
                   $time, act.mm, act.er, act.nerr, act.cyc, act.fcyc, act.fmask, act.busy, act.done, act.pass,
                   e.mm, e.er, e.nerr, e.cyc, e.fcyc, e.fmask, e.busy, e.done, e.pass);
        end
      end
    end
  end

  initial begin : driver
    model_clear();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_state: got %h, expected 0", act); end
    step(1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); reset = 1'b1; hold();

    // matching counting vectors
    run(0, -1, '0, 1'b0);
    settle();
    chk("match_done", 64'(done_o), 64'd1);
    chk("match_pass", 64'(pass_o), 64'd1);
    chk("match_cycle", 64'(cycle_o), 64'd10);
    hold();

    // single persistent error on bit 3
    run(1, -1, '0, 1'b0);
    settle();
    chk("bit3_nerr", 64'(nb_error_o), 64'd1);
    chk("bit3_fcyc", 64'(first_cycle_o), 64'd4);
    chk("bit3_fmask", 64'(first_mask_o), 64'h08);
    chk("bit3_pass", 64'(pass_o), 64'd0);
    hold();

    // multi-bit and re-rising errors
    run(2, -1, '0, 1'b0);
    settle();
    chk("toggle_nerr", 64'(nb_error_o), 64'd4);
    chk("toggle_fmask", 64'(first_mask_o), 64'h83);
    hold();

    // don't-care masking
    run(3, -1, 8'hFF, 1'b0);
    settle();
    chk("dc_all_pass", 64'(pass_o), 64'd1);
    hold();
    run(3, -1, 8'hFE, 1'b0);
    settle();
    chk("dc_bit0_nerr", 64'(nb_error_o), 64'd1);
    hold();

    // early stop, ignored start in CHECK, restart from DONE
    run(5, 3, '0, 1'b0);
    settle();
    chk("stop_done", 64'(done_o), 64'd1);
    chk("stop_cycle", 64'(cycle_o), 64'd4);
    apply(1'b1, 1'b0, '0, '0, '0);
    settle();
    chk("restart_busy", 64'(busy_o), 64'd1);
    chk("restart_nerr", 64'(nb_error_o), 64'd0);
    chk("restart_cycle", 64'(cycle_o), 64'd0);
    hold();
    for (int j = 0; j < SKIP + RUN; j++) step(1'b0, 1'b0, 8'h5A, 8'h5A, '0);
    settle();
    chk("restart_pass", 64'(pass_o), 64'd1);
    hold();

    // stop during SKIP
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 8'hFF, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0);

    // randomized runs with random stops and stray start pulses
    for (int r = 0; r < 6; r++) run(6, $urandom_range(0, RUN), '0, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, W'($urandom), W'($urandom), '0);

    // async reset mid-CHECK
    step(1'b1, 1'b0, '0, '0, '0);
    for (int j = 0; j < SKIP; j++) step(1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h11 ^ err_mask(7, k), 8'h11, '0);
    settle();
    chk("prerst_nerr", 64'(nb_error_o), 64'd2);
    chk("prerst_busy", 64'(busy_o), 64'd1);
    start_i = 1'b0; stop_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin errors++; $display("FAIL async_reset: got %h, expected 0", act); end
    model_step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); reset = 1'b1; hold();
    run(0, -1, '0, 1'b0);
    settle();
    chk("postrst_pass", 64'(pass_o), 64'd1);
    chk("postrst_cycle", 64'(cycle_o), 64'd10);
    hold();

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
